// File: rtl/accumulator_18_if.sv
// Flux-indexed FIFO read port and single write port shared by the accumulate stage.
// master is the side that issues read/write strobes; slave is the FIFO side.
interface read_interface #(
    parameter int DATA_WIDTH = 8,
    parameter int FLUX       = 2
);
    logic [FLUX-1:0]       empty;
    logic [FLUX-1:0]       read;
    logic [DATA_WIDTH-1:0] dout;

    modport master (input empty, input dout, output read);
    modport slave  (output empty, output dout, input read);
endinterface

interface write_interface #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] din;
    logic                  write;
    logic                  full;

    modport master (output din, output write, input full);
    modport slave  (input din, input write, output full);
endinterface

// File: rtl/accumulator_18.sv
// Multi-flux accumulate / round / saturate stage behind the coefficient multiplier.
// One flux acts per cycle; the lowest eligible flux index wins arbitration.
module accumulator_18 #(
    parameter int FLUX                = 2,
    parameter int TAG_WIDTH           = $clog2(FLUX),
    parameter int DATA_WIDTH_PROD     = 18,
    parameter int DATA_WIDTH_EXT_SIZE = 7,
    parameter int DATA_WIDTH_SHIFT    = 5,
    parameter int ACC_WIDTH           = DATA_WIDTH_PROD + DATA_WIDTH_EXT_SIZE,
    parameter int DATA_WIDTH_OUT      = 16
) (
    input  logic            clk,
    input  logic            rst,
    read_interface.master   read_port_prod,
    read_interface.master   read_port_ext_size,
    read_interface.master   read_port_shift,
    write_interface.master  write_port_sum
);

    localparam int SHIFT_MAX = ACC_WIDTH - 1;
    localparam logic signed [ACC_WIDTH:0] OUT_MAX = (ACC_WIDTH+1)'(2 ** (DATA_WIDTH_OUT - 1) - 1);
    localparam logic signed [ACC_WIDTH:0] OUT_MIN = -OUT_MAX - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                         state_reg [FLUX];
    state_t                         state_next[FLUX];
    logic signed [ACC_WIDTH-1:0]    acc_reg   [FLUX];
    logic signed [ACC_WIDTH-1:0]    acc_next  [FLUX];
    logic [DATA_WIDTH_EXT_SIZE-1:0] cnt_reg   [FLUX];
    logic [DATA_WIDTH_EXT_SIZE-1:0] cnt_next  [FLUX];
    logic [DATA_WIDTH_EXT_SIZE-1:0] max_reg   [FLUX];
    logic [DATA_WIDTH_EXT_SIZE-1:0] max_next  [FLUX];
    logic [DATA_WIDTH_SHIFT-1:0]    shift_reg [FLUX];
    logic [DATA_WIDTH_SHIFT-1:0]    shift_next[FLUX];

    logic [FLUX-1:0]      elig;
    logic [FLUX-1:0]      act;
    logic [FLUX-1:0]      rd_tok;
    logic [FLUX-1:0]      rd_prod;
    logic                 wr_strobe;
    logic [TAG_WIDTH-1:0] tag;
    logic                 any_elig;

    // Incoming tags are ignored: the port index identifies the flux.
    logic [DATA_WIDTH_PROD-1:0]     prod_data;
    logic [DATA_WIDTH_EXT_SIZE-1:0] ext_data;
    logic [DATA_WIDTH_SHIFT-1:0]    shift_data;
    logic signed [ACC_WIDTH-1:0]    prod_sext;
    logic                           unused_tags;

    assign prod_data   = read_port_prod.dout[DATA_WIDTH_PROD-1:0];
    assign ext_data    = read_port_ext_size.dout[DATA_WIDTH_EXT_SIZE-1:0];
    assign shift_data  = read_port_shift.dout[DATA_WIDTH_SHIFT-1:0];
    assign prod_sext   = {{(ACC_WIDTH-DATA_WIDTH_PROD){prod_data[DATA_WIDTH_PROD-1]}}, prod_data};
    assign unused_tags = ^{read_port_prod.dout[DATA_WIDTH_PROD+TAG_WIDTH-1:DATA_WIDTH_PROD],
                           read_port_ext_size.dout[DATA_WIDTH_EXT_SIZE+TAG_WIDTH-1:DATA_WIDTH_EXT_SIZE],
                           read_port_shift.dout[DATA_WIDTH_SHIFT+TAG_WIDTH-1:DATA_WIDTH_SHIFT]};

    generate
        for (genvar gi = 0; gi < FLUX; gi++) begin : gen_elig
            assign elig[gi] = ((state_reg[gi] == IDLE) && !read_port_ext_size.empty[gi]
                                                       && !read_port_shift.empty[gi])
                           || ((state_reg[gi] == ACC)  && !read_port_prod.empty[gi])
                           || ((state_reg[gi] == OUT)  && !write_port_sum.full);
        end
    endgenerate

    always_comb begin
        tag      = '0;
        any_elig = 1'b0;
        for (int i = FLUX - 1; i >= 0; i--) begin
            if (elig[i]) begin
                tag      = TAG_WIDTH'(i);
                any_elig = 1'b1;
            end
        end
        act = '0;
        if (rst && any_elig) begin
            act[tag] = 1'b1;
        end
    end

    always_comb begin
        rd_tok    = '0;
        rd_prod   = '0;
        wr_strobe = 1'b0;
        for (int i = 0; i < FLUX; i++) begin
            rd_tok[i]  = act[i] && (state_reg[i] == IDLE);
            rd_prod[i] = act[i] && (state_reg[i] == ACC);
            if (act[i] && (state_reg[i] == OUT)) begin
                wr_strobe = 1'b1;
            end
        end
    end

    assign read_port_ext_size.read = rd_tok;
    assign read_port_shift.read    = rd_tok;
    assign read_port_prod.read     = rd_prod;
    assign write_port_sum.write    = wr_strobe;

    // Rounding is done one bit wider than the accumulator so the bias add never overflows.
    logic [DATA_WIDTH_SHIFT-1:0]  sh_eff;
    logic signed [ACC_WIDTH:0]    acc_wide;
    logic signed [ACC_WIDTH:0]    rnd_bias;
    logic signed [ACC_WIDTH:0]    rounded;
    logic [DATA_WIDTH_OUT-1:0]    sat_out;

    always_comb begin
        sh_eff   = (shift_reg[tag] > DATA_WIDTH_SHIFT'(SHIFT_MAX)) ? DATA_WIDTH_SHIFT'(SHIFT_MAX)
                                                                   : shift_reg[tag];
        acc_wide = {acc_reg[tag][ACC_WIDTH-1], acc_reg[tag]};
        rnd_bias = '0;
        rounded  = acc_wide;
        if (sh_eff != '0) begin
            rnd_bias = (ACC_WIDTH+1)'(1) << (sh_eff - 1'b1);
            rounded  = (acc_wide + rnd_bias) >>> sh_eff;
        end
        if (rounded > OUT_MAX) begin
            sat_out = OUT_MAX[DATA_WIDTH_OUT-1:0];
        end else if (rounded < OUT_MIN) begin
            sat_out = OUT_MIN[DATA_WIDTH_OUT-1:0];
        end else begin
            sat_out = rounded[DATA_WIDTH_OUT-1:0];
        end
    end

    assign write_port_sum.din = {tag, sat_out};

    always_comb begin
        for (int i = 0; i < FLUX; i++) begin
            state_next[i] = state_reg[i];
            acc_next[i]   = acc_reg[i];
            cnt_next[i]   = cnt_reg[i];
            max_next[i]   = max_reg[i];
            shift_next[i] = shift_reg[i];
            if (act[i]) begin
                case (state_reg[i])
                    IDLE: begin
                        max_next[i]   = ext_data;
                        shift_next[i] = shift_data;
                        acc_next[i]   = '0;
                        cnt_next[i]   = '0;
                        state_next[i] = (ext_data == '0) ? OUT : ACC;
                    end
                    ACC: begin
                        acc_next[i] = acc_reg[i] + prod_sext;
                        cnt_next[i] = cnt_reg[i] + 1'b1;
                        if (({1'b0, cnt_reg[i]} + 1'b1) == {1'b0, max_reg[i]}) begin
                            state_next[i] = OUT;
                        end
                    end
                    OUT: begin
                        state_next[i] = IDLE;
                        cnt_next[i]   = '0;
                    end
                    default: state_next[i] = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FLUX; i++) begin
                state_reg[i] <= IDLE;
                acc_reg[i]   <= '0;
                cnt_reg[i]   <= '0;
                max_reg[i]   <= '0;
                shift_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < FLUX; i++) begin
                state_reg[i] <= state_next[i];
                acc_reg[i]   <= acc_next[i];
                cnt_reg[i]   <= cnt_next[i];
                max_reg[i]   <= max_next[i];
                shift_reg[i] <= shift_next[i];
            end
        end
    end

endmodule
